playseq_unidade_controle: RTL and testbench
===========================================

PLAYSEQ_UNIDADE_CONTROLE -- requirements
Module: playseq_unidade_controle

Interface
REQ-001 SHALL have clock (in, 1): single rising-edge clock; all state changes on this edge.
REQ-002 SHALL have reset (in, 1): synchronous, active-high; there is one clock only.
REQ-003 SHALL have iniciar (in, 1): level; starts a game from inicial or fim_jogo.
REQ-004 SHALL have igual (in, 1): registered play equals memory data.
REQ-005 SHALL have enderecoIgualSequencia (in, 1): address counter equals the current round length.
REQ-006 SHALL have fimE (in, 1): address counter at the last sequence position.
REQ-007 SHALL have tem_jogada (in, 1): one-cycle pulse on a new button press.
REQ-008 SHALL have controle_timeout (in, 1): play timeout expired; datapath already masks it with ignora_timeout.
REQ-009 SHALL have controle_timeout_led (in, 1): LED preview interval elapsed; the timer wraps by itself.
REQ-010 SHALL have the following datapath-control outputs (out, 1 each), active-high:
- zeraE, contaE: address counter.
- zeraS, contaS, carregaS: round-length counter.
- zeraR, registraR: play register.
- zeraT, contaT: play timer.
- zeraT_leds, contaT_leds: LED timer.
- controla_leds, fase_preview: LED source.
- ignora_timeout.
- conta_ganhar, conta_perder, zera_metricas: metric counters.
REQ-011 SHALL have pronto, ganhou, perdeu (out, 1 each): game ended; result flags.
REQ-012 SHALL have db_estado (out, 4): current state code.

Function
REQ-013 SHALL be a Moore FSM.
- 4-bit state codes: inicial=0, preparacao=1, inicia_rodada=2, mostra_led=3, apaga_led=4, proximo_preview=5, fim_preview=6, espera_jogada=7, registra=8, compara=9, proxima_jogada=A, fim_rodada=B, proxima_rodada=C, conta_vitoria=D, conta_derrota=E, fim_jogo=F.
- Control outputs decode from the state register only.
REQ-014 SHALL follow these transitions:
- inicial→preparacao if iniciar.
- preparacao→inicia_rodada→mostra_led.
- mostra_led→apaga_led on controle_timeout_led.
- apaga_led on controle_timeout_led: →fim_preview if enderecoIgualSequencia, else →proximo_preview.
- proximo_preview→mostra_led.
- fim_preview→espera_jogada.
REQ-015 SHALL follow these transitions in play:
- espera_jogada→registra on tem_jogada, else →conta_derrota on controle_timeout; tem_jogada wins when both are set in the same cycle.
- registra→compara.
- compara: →conta_derrota if !igual; else →fim_rodada if enderecoIgualSequencia; else →proxima_jogada.
- proxima_jogada→espera_jogada.
REQ-016 SHALL follow these transitions at round end:
- fim_rodada→conta_vitoria if fimE, else →proxima_rodada→inicia_rodada.
- conta_vitoria/conta_derrota→fim_jogo.
- fim_jogo→preparacao if iniciar, else hold.
REQ-017 SHALL assert these outputs per state:
- inicial: zeraE, zeraS, zeraR, zeraT, zeraT_leds, zera_metricas.
- preparacao: zeraE, carregaS, zeraR, zeraT.
- inicia_rodada and proximo_preview: zeraT_leds; proximo_preview also contaE.
- mostra_led: fase_preview, controla_leds, contaT_leds.
- apaga_led: fase_preview, contaT_leds.
- fim_preview: zeraE, zeraT.
- espera_jogada: contaT.
- registra: registraR.
- proxima_jogada: contaE, zeraT.
- proxima_rodada: contaS, zeraE.
- conta_vitoria: conta_ganhar.
- conta_derrota: conta_perder.
- All other outputs are 0.
REQ-018 SHALL assert ignora_timeout in every state except espera_jogada.
REQ-019 SHALL register ganhou and perdeu:
- Set on entering conta_vitoria or conta_derrota respectively.
- Cleared in preparacao.
- Held through fim_jogo.
REQ-020 SHALL assert pronto only in fim_jogo.
REQ-021 SHALL pulse conta_ganhar and conta_perder for exactly one cycle per game; a timeout counts as a loss.

Reset
REQ-022 SHALL, on reset=1 at any clock edge (including mid-preview or mid-play), enter inicial on that edge.
REQ-023 SHALL set ganhou=perdeu=pronto=0 and db_estado=0 after reset; metric counters clear through zera_metricas in inicial.

Structure
REQ-024 SHALL take state encodings from a shared package playseq_pkg, which is also used by the top level for db_estado display.
REQ-025 SHALL be a single module with no sub-modules: state register, next-state logic, output decode, two result flops.

Verification
REQ-026 SHALL cover a win:
- Stimulus: reset, iniciar, 2-step round, correct plays, fimE=1 at the end.
- Response: fim_jogo; ganhou=1, pronto=1; conta_ganhar high exactly 1 cycle.
REQ-027 SHALL cover a wrong play: igual=0 in compara → conta_derrota, then fim_jogo with perdeu=1, ganhou=0.
REQ-028 SHALL cover a timeout:
- Stimulus: controle_timeout=1 in espera_jogada.
- Response: db_estado 7→E→F; perdeu=1.
- Also drive controle_timeout=1 in mostra_led: no effect.
REQ-029 SHALL cover simultaneous tem_jogada=1 and controle_timeout=1 in espera_jogada → db_estado=8 next cycle.
REQ-030 SHALL cover reset asserted in apaga_led and in compara → db_estado=0 next cycle; zera_metricas=1; ganhou=perdeu=0.
REQ-031 SHALL cover preview length: round length 3 → exactly 3 mostra_led visits, each ended by controle_timeout_led, before fim_preview.

Source files
------------

// File: rtl/playseq_pkg.sv
// Shared definitions for the playseq game controller.
// Holds the 4-bit state encoding. The controller uses it for its state
// register, and the top level uses the same codes for the db_estado display.
package playseq_pkg;

    localparam int ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        st_inicial         = 4'h0,
        st_preparacao      = 4'h1,
        st_inicia_rodada   = 4'h2,
        st_mostra_led      = 4'h3,
        st_apaga_led       = 4'h4,
        st_proximo_preview = 4'h5,
        st_fim_preview     = 4'h6,
        st_espera_jogada   = 4'h7,
        st_registra        = 4'h8,
        st_compara         = 4'h9,
        st_proxima_jogada  = 4'hA,
        st_fim_rodada      = 4'hB,
        st_proxima_rodada  = 4'hC,
        st_conta_vitoria   = 4'hD,
        st_conta_derrota   = 4'hE,
        st_fim_jogo        = 4'hF
    } estado_t;

endpackage

// File: rtl/playseq_unidade_controle.sv
// Control unit (Moore FSM) for the playseq memory game.
// Each round first previews the sequence on the LEDs and then collects the
// player's presses. A wrong press or a timeout ends the game as a loss.
// Completing the final round ends it as a win.
//
// Ports:
//   clock, reset               : single clock; synchronous active-high reset
//   iniciar                    : start a game (level)
//   igual                      : registered play matches memory
//   enderecoIgualSequencia     : address counter == current round length
//   fimE                       : address counter at the last position
//   tem_jogada                 : one-cycle pulse for a new button press
//   controle_timeout           : play timeout (already masked by ignora_timeout)
//   controle_timeout_led       : LED preview interval elapsed
//   zeraE..zera_metricas       : datapath control strobes (active-high)
//   pronto, ganhou, perdeu     : game finished and its result
//   db_estado                  : current state code for debug display
module playseq_unidade_controle
    import playseq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       enderecoIgualSequencia,
    input  logic       fimE,
    input  logic       tem_jogada,
    input  logic       controle_timeout,
    input  logic       controle_timeout_led,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       carregaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraT_leds,
    output logic       contaT_leds,
    output logic       controla_leds,
    output logic       fase_preview,
    output logic       ignora_timeout,
    output logic       conta_ganhar,
    output logic       conta_perder,
    output logic       zera_metricas,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    estado_t state_reg, state_next;
    logic    ganhou_reg, perdeu_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= st_inicial;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            st_inicial:         if (iniciar) state_next = st_preparacao;
            st_preparacao:      state_next = st_inicia_rodada;
            st_inicia_rodada:   state_next = st_mostra_led;
            st_mostra_led:      if (controle_timeout_led) state_next = st_apaga_led;
            st_apaga_led:
                if (controle_timeout_led)
                    state_next = enderecoIgualSequencia ? st_fim_preview : st_proximo_preview;
            st_proximo_preview: state_next = st_mostra_led;
            st_fim_preview:     state_next = st_espera_jogada;
            // A press takes priority over a timeout arriving in the same cycle.
            st_espera_jogada:
                if (tem_jogada)            state_next = st_registra;
                else if (controle_timeout) state_next = st_conta_derrota;
            st_registra:        state_next = st_compara;
            st_compara:
                if (!igual)                      state_next = st_conta_derrota;
                else if (enderecoIgualSequencia) state_next = st_fim_rodada;
                else                             state_next = st_proxima_jogada;
            st_proxima_jogada:  state_next = st_espera_jogada;
            st_fim_rodada:      state_next = fimE ? st_conta_vitoria : st_proxima_rodada;
            st_proxima_rodada:  state_next = st_inicia_rodada;
            st_conta_vitoria:   state_next = st_fim_jogo;
            st_conta_derrota:   state_next = st_fim_jogo;
            st_fim_jogo:        if (iniciar) state_next = st_preparacao;
            default:            state_next = st_inicial;
        endcase
    end

    // Result flags are set on the same edge that enters the counting state.
    // They are cleared on entry to preparacao, so they read 0 from
    // preparacao onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            ganhou_reg <= 1'b0;
            perdeu_reg <= 1'b0;
        end else if (state_next == st_preparacao) begin
            ganhou_reg <= 1'b0;
            perdeu_reg <= 1'b0;
        end else begin
            if (state_next == st_conta_vitoria) ganhou_reg <= 1'b1;
            if (state_next == st_conta_derrota) perdeu_reg <= 1'b1;
        end
    end

    always_comb begin
        zeraE          = 1'b0;
        contaE         = 1'b0;
        zeraS          = 1'b0;
        contaS         = 1'b0;
        carregaS       = 1'b0;
        zeraR          = 1'b0;
        registraR      = 1'b0;
        zeraT          = 1'b0;
        contaT         = 1'b0;
        zeraT_leds     = 1'b0;
        contaT_leds    = 1'b0;
        controla_leds  = 1'b0;
        fase_preview   = 1'b0;
        conta_ganhar   = 1'b0;
        conta_perder   = 1'b0;
        zera_metricas  = 1'b0;
        ignora_timeout = (state_reg != st_espera_jogada);
        pronto         = (state_reg == st_fim_jogo);
        case (state_reg)
            st_inicial: begin
                zeraE = 1'b1; zeraS = 1'b1; zeraR = 1'b1; zeraT = 1'b1;
                zeraT_leds = 1'b1; zera_metricas = 1'b1;
            end
            st_preparacao: begin
                zeraE = 1'b1; carregaS = 1'b1; zeraR = 1'b1; zeraT = 1'b1;
            end
            st_inicia_rodada:   zeraT_leds = 1'b1;
            st_proximo_preview: begin
                zeraT_leds = 1'b1; contaE = 1'b1;
            end
            st_mostra_led: begin
                fase_preview = 1'b1; controla_leds = 1'b1; contaT_leds = 1'b1;
            end
            st_apaga_led: begin
                fase_preview = 1'b1; contaT_leds = 1'b1;
            end
            st_fim_preview: begin
                zeraE = 1'b1; zeraT = 1'b1;
            end
            st_espera_jogada:   contaT = 1'b1;
            st_registra:        registraR = 1'b1;
            st_proxima_jogada: begin
                contaE = 1'b1; zeraT = 1'b1;
            end
            st_proxima_rodada: begin
                contaS = 1'b1; zeraE = 1'b1;
            end
            st_conta_vitoria:   conta_ganhar = 1'b1;
            st_conta_derrota:   conta_perder = 1'b1;
            default: ;
        endcase
    end

    assign ganhou    = ganhou_reg;
    assign perdeu    = perdeu_reg;
    assign db_estado = state_reg;

endmodule

// File: tb/tb_playseq_unidade_controle.sv
// Directed testbench for playseq_unidade_controle.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_playseq_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, igual = 1'b0, enderecoIgualSequencia = 1'b0, fimE = 1'b0;
    logic       tem_jogada = 1'b0, controle_timeout = 1'b0, controle_timeout_led = 1'b0;
    logic       zeraE, contaE, zeraS, contaS, carregaS, zeraR, registraR, zeraT, contaT;
    logic       zeraT_leds, contaT_leds, controla_leds, fase_preview, ignora_timeout;
    logic       conta_ganhar, conta_perder, zera_metricas, pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int visits;
    int win_pulses = 0;

    playseq_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
        .enderecoIgualSequencia(enderecoIgualSequencia), .fimE(fimE),
        .tem_jogada(tem_jogada), .controle_timeout(controle_timeout),
        .controle_timeout_led(controle_timeout_led),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .carregaS(carregaS), .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT),
        .contaT(contaT), .zeraT_leds(zeraT_leds), .contaT_leds(contaT_leds),
        .controla_leds(controla_leds), .fase_preview(fase_preview),
        .ignora_timeout(ignora_timeout), .conta_ganhar(conta_ganhar),
        .conta_perder(conta_perder), .zera_metricas(zera_metricas),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Counts cycles with conta_ganhar high, sampled at the falling edge.
    always @(negedge clock) if (conta_ganhar) win_pulses++;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starts a game and stops in mostra_led.
    task automatic start_game();
        iniciar = 1'b1; step();
        check_value("prep_state", db_estado, 4'h1);
        iniciar = 1'b0; step();
        check_value("inicia_state", db_estado, 4'h2);
        step();
        check_value("mostra_state", db_estado, 4'h3);
    endtask

    // Runs a one-LED preview from mostra_led into espera_jogada.
    task automatic preview_one();
        controle_timeout_led = 1'b1; step();
        check_value("apaga_state", db_estado, 4'h4);
        enderecoIgualSequencia = 1'b1; step();
        check_value("fimprev_state", db_estado, 4'h6);
        controle_timeout_led = 1'b0; enderecoIgualSequencia = 1'b0; step();
        check_value("espera_state", db_estado, 4'h7);
    endtask

    initial begin
        // Reset state.
        step(); step();
        check_value("rst_state", db_estado, 4'h0);
        check_value("rst_zera_metricas", zera_metricas, 1);
        check_value("rst_pronto", pronto, 0);
        check_value("rst_ganhou", ganhou, 0);
        check_value("rst_perdeu", perdeu, 0);
        check_value("rst_ignora", ignora_timeout, 1);
        reset = 1'b0;
        step();
        check_value("inicial_hold", db_estado, 4'h0);

        // Win: a 2-step round that is also the final round.
        start_game();
        check_value("mostra_leds", controla_leds, 1);
        controle_timeout_led = 1'b1; step();
        check_value("apaga1", db_estado, 4'h4);
        check_value("apaga_leds_off", controla_leds, 0);
        step();
        check_value("proxprev", db_estado, 4'h5);
        check_value("proxprev_contaE", contaE, 1);
        step();
        check_value("mostra2", db_estado, 4'h3);
        step();
        check_value("apaga2", db_estado, 4'h4);
        enderecoIgualSequencia = 1'b1; step();
        check_value("fimprev", db_estado, 4'h6);
        controle_timeout_led = 1'b0; enderecoIgualSequencia = 1'b0; step();
        check_value("espera", db_estado, 4'h7);
        check_value("espera_ignora", ignora_timeout, 0);
        check_value("espera_contaT", contaT, 1);
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        check_value("registra", db_estado, 4'h8);
        check_value("registraR", registraR, 1);
        step();
        check_value("compara", db_estado, 4'h9);
        igual = 1'b1; step();
        check_value("proxjog", db_estado, 4'hA);
        step();
        check_value("espera2", db_estado, 4'h7);
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        step();
        check_value("compara2", db_estado, 4'h9);
        enderecoIgualSequencia = 1'b1; step();
        check_value("fimrodada", db_estado, 4'hB);
        enderecoIgualSequencia = 1'b0; igual = 1'b0; fimE = 1'b1; step();
        check_value("vitoria", db_estado, 4'hD);
        check_value("conta_ganhar_on", conta_ganhar, 1);
        fimE = 1'b0; step();
        check_value("fimjogo_win", db_estado, 4'hF);
        check_value("conta_ganhar_off", conta_ganhar, 0);
        check_value("win_ganhou", ganhou, 1);
        check_value("win_perdeu", perdeu, 0);
        check_value("win_pronto", pronto, 1);
        step();
        check_value("fimjogo_hold", db_estado, 4'hF);
        check_value("win_pulse_count", win_pulses, 1);

        // Wrong play.
        start_game();
        check_value("prep_clears_ganhou", ganhou, 0);
        preview_one();
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        step();
        igual = 1'b0; step();
        check_value("derrota", db_estado, 4'hE);
        check_value("conta_perder", conta_perder, 1);
        step();
        check_value("fimjogo_lose", db_estado, 4'hF);
        check_value("lose_perdeu", perdeu, 1);
        check_value("lose_ganhou", ganhou, 0);

        // Timeout, including a timeout pulse in mostra_led that must be ignored.
        start_game();
        controle_timeout = 1'b1; step();
        check_value("to_in_mostra", db_estado, 4'h3);
        controle_timeout = 1'b0;
        preview_one();
        controle_timeout = 1'b1; step(); controle_timeout = 1'b0;
        check_value("to_derrota", db_estado, 4'hE);
        step();
        check_value("to_fimjogo", db_estado, 4'hF);
        check_value("to_perdeu", perdeu, 1);

        // Press and timeout in the same cycle: the press wins.
        start_game();
        preview_one();
        tem_jogada = 1'b1; controle_timeout = 1'b1; step();
        tem_jogada = 1'b0; controle_timeout = 1'b0;
        check_value("both_registra", db_estado, 4'h8);
        step();
        check_value("both_compara", db_estado, 4'h9);
        // Reset taken in compara.
        reset = 1'b1; step();
        check_value("rst_compara", db_estado, 4'h0);
        check_value("rst_compara_zm", zera_metricas, 1);
        check_value("rst_compara_g", ganhou, 0);
        check_value("rst_compara_p", perdeu, 0);
        reset = 1'b0;

        // Preview of round length 3.
        visits = 0;
        start_game();
        controle_timeout_led = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (db_estado == 4'h3) visits++;
            step();
            check_value("prev3_apaga", db_estado, 4'h4);
            if (k == 2) enderecoIgualSequencia = 1'b1;
            step();
            if (k < 2) begin
                check_value("prev3_prox", db_estado, 4'h5);
                step();
            end
        end
        controle_timeout_led = 1'b0; enderecoIgualSequencia = 1'b0;
        check_value("prev3_fim", db_estado, 4'h6);
        check_value("prev3_visits", visits, 3);

        // Reset taken in apaga_led, after a lost game left perdeu set.
        step();
        controle_timeout = 1'b1; step(); controle_timeout = 1'b0;
        step();
        check_value("pre_rst_perdeu", perdeu, 1);
        start_game();
        controle_timeout_led = 1'b1; step(); controle_timeout_led = 1'b0;
        check_value("pre_rst_apaga", db_estado, 4'h4);
        reset = 1'b1; step();
        check_value("rst_apaga", db_estado, 4'h0);
        check_value("rst_apaga_zm", zera_metricas, 1);
        check_value("rst_apaga_g", ganhou, 0);
        check_value("rst_apaga_p", perdeu, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
